// File: rtl/cmp_sort_ctrl_if.sv
// Loader/consumer bus for cmp_sort_ctrl: load, sort control and
// sorted readback. master = loader/consumer side, slave = sorter.
interface cmp_sort_ctrl_if #(
    parameter int DEPTH  = 4,
    parameter int SWAP_W = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic              clr;
    logic              wr_en;
    logic [3:0]        wr_data;
    logic              full;
    logic              start;
    logic              busy;
    logic              done;
    logic [CW-1:0]     count;
    logic [AW-1:0]     rd_addr;
    logic [3:0]        rd_data;
    logic [SWAP_W-1:0] swap_cnt;

    modport master (
        output clr, wr_en, wr_data, start, rd_addr,
        input  full, busy, done, count, rd_data, swap_cnt
    );

    modport slave (
        input  clr, wr_en, wr_data, start, rd_addr,
        output full, busy, done, count, rd_data, swap_cnt
    );
endinterface

// File: rtl/cmp_sort_ctrl.sv
// Bubble-sort scheduler sharing one 4-bit comparator, one compare per cycle.
// Define CMP_SORT_EARLY_EXIT_EN to stop after the first pass with no swap.
module comparator_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       eql,
    output logic       grt,
    output logic       less
);
    assign eql  = (a == b);
    assign grt  = (a > b);
    assign less = (a < b);
endmodule

module cmp_sort_ctrl #(
    parameter int DEPTH  = 4,
    parameter int SWAP_W = 8
) (
    input logic           clk,
    input logic           rst,
    cmp_sort_ctrl_if.slave s
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        mem [DEPTH];
    logic [CW-1:0]     count;
    logic [AW-1:0]     i;
    logic [AW-1:0]     i1;
    logic [AW-1:0]     pass;
    logic [SWAP_W-1:0] swap_cnt;
    logic [3:0]        ca;
    logic [3:0]        cb;
    logic              eql;
    logic              grt;
    logic              less;
    logic              do_swap;
    logic              last_i;
    logic              last_pass;
    logic              early;
    logic              full;

    assign i1 = i + AW'(1);
    assign ca = mem[i];
    assign cb = mem[i1];

    comparator_4bit u_cmp (
        .a    (ca),
        .b    (cb),
        .eql  (eql),
        .grt  (grt),
        .less (less)
    );

    // eql/less both mean "keep order", which keeps the sort stable
    assign do_swap   = (state == SORT) && grt && !(eql || less);
    assign last_i    = (CW'(i) == count - CW'(2) - CW'(pass));
    assign last_pass = (CW'(pass) == count - CW'(2));
    assign full      = (count == CW'(DEPTH));

`ifdef CMP_SORT_EARLY_EXIT_EN
    logic pass_swapped;

    assign early = !(pass_swapped || do_swap);

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_swapped <= 1'b0;
        end else if (state != SORT || last_i) begin
            pass_swapped <= 1'b0;
        end else if (do_swap) begin
            pass_swapped <= 1'b1;
        end
    end
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (s.start) begin
                    state_nx = (count < CW'(2)) ? DONE : SORT;
                end
            end
            SORT: begin
                if (last_i && (last_pass || early)) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            swap_cnt <= '0;
            i        <= '0;
            pass     <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= 4'd0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (s.start) begin
                        swap_cnt <= '0;
                        i        <= '0;
                        pass     <= '0;
                    end else if (s.clr) begin
                        count <= '0;
                    end else if (s.wr_en && !full) begin
                        mem[count[AW-1:0]] <= s.wr_data;
                        count              <= count + CW'(1);
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        mem[i]  <= cb;
                        mem[i1] <= ca;
                        if (swap_cnt != {SWAP_W{1'b1}}) begin
                            swap_cnt <= swap_cnt + SWAP_W'(1);
                        end
                    end
                    if (last_i) begin
                        i    <= '0;
                        pass <= pass + AW'(1);
                    end else begin
                        i <= i1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s.full     = full;
    assign s.busy     = (state == SORT);
    assign s.done     = (state == DONE);
    assign s.count    = count;
    assign s.swap_cnt = swap_cnt;
    assign s.rd_data  = (CW'(s.rd_addr) < count) ? mem[s.rd_addr] : 4'd0;
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Scoreboard bench for cmp_sort_ctrl: a reference model predicts each sort,
// a monitor checks every done pulse against the queued prediction.
`timescale 1ns/1ps
module tb_cmp_sort_ctrl;
    localparam int DEPTH = 4;

    typedef struct {
        int          s;
        int          n;
        int          sw;
        int          cnt;
        logic [15:0] v;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    item_t sb[$];

    logic       mon_rd = 1'b0;
    logic [1:0] mon_addr = '0;
    logic [1:0] stim_addr = '0;

    int mdl[DEPTH];
    int mcnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cmp_sort_ctrl_if #(.DEPTH(DEPTH), .SWAP_W(8)) bus ();

    cmp_sort_ctrl #(.DEPTH(DEPTH), .SWAP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus.slave)
    );

    assign bus.rd_addr = mon_rd ? mon_addr : stim_addr;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: swaps = inversions, passes bounded by the largest
    // leftward displacement when early exit is enabled.
    function automatic item_t model();
        item_t e;
        int q[$];
        int li;
        int lmax;
        int inv;
        int p_n;
        lmax = 0;
        inv  = 0;
        e.cnt = mcnt;
        e.v   = '0;
        e.s   = 0;
        for (int a = 0; a < mcnt; a++) begin
            li = 0;
            for (int b = 0; b < a; b++) begin
                if (mdl[b] > mdl[a]) li++;
            end
            inv += li;
            if (li > lmax) lmax = li;
            q.push_back(mdl[a]);
        end
        q.sort();
        for (int a = 0; a < mcnt; a++) begin
            e.v[4*a +: 4] = 4'(q[a]);
        end
        p_n = (mcnt < 2) ? 0 : mcnt - 1;
`ifdef CMP_SORT_EARLY_EXIT_EN
        if (mcnt >= 2 && lmax + 1 < p_n) p_n = lmax + 1;
`endif
        e.n = 0;
        for (int p = 0; p < p_n; p++) begin
            e.n += mcnt - 1 - p;
        end
        e.sw = inv;
        return e;
    endfunction

    initial begin : monitor
        item_t e;
        int busy_n;
        busy_n = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_n = 0;
            end else begin
                if (bus.busy) busy_n++;
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        chk("spurious_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cycle", cyc - e.s + 1, e.n + 1);
                        chk("busy_cycles", busy_n, e.n);
                        chk("swap_cnt", int'(bus.swap_cnt), e.sw);
                        chk("count", int'(bus.count), e.cnt);
                        mon_rd = 1'b1;
                        for (int a = 0; a < DEPTH; a++) begin
                            mon_addr = 2'(a);
                            #1;
                            chk($sformatf("rd_data[%0d]", a), int'(bus.rd_data),
                                (a < e.cnt) ? int'(e.v[4*a +: 4]) : 0);
                        end
                        mon_rd = 1'b0;
                    end
                    busy_n = 0;
                end
            end
        end
    end

    task automatic wr(input int v);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = 4'(v);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        if (mcnt < DEPTH) begin
            mdl[mcnt] = v;
            mcnt++;
        end
    endtask

    task automatic clr();
        @(negedge clk);
        bus.clr = 1'b1;
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
        mcnt = 0;
    endtask

    task automatic go(input bit disturb);
        item_t e;
        int k;
        e = model();
        @(negedge clk);
        bus.start = 1'b1;
        e.s = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (disturb) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 4'hF;
            bus.clr     = 1'b1;
            bus.start   = 1'b1;
            @(posedge clk);
            #1;
            bus.wr_en = 1'b0;
            bus.clr   = 1'b0;
            bus.start = 1'b0;
        end
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
        for (int a = 0; a < mcnt; a++) begin
            mdl[a] = int'(e.v[4*a +: 4]);
        end
    endtask

    task automatic load(input int v0, input int v1, input int v2, input int v3, input int n);
        int vs[4];
        vs = '{v0, v1, v2, v3};
        clr();
        for (int a = 0; a < n; a++) wr(vs[a]);
    endtask

    initial begin : stim
        int n;
        rst         = 1'b1;
        bus.clr     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_swap_cnt", int'(bus.swap_cnt), 0);
        chk("rst_rd_data", int'(bus.rd_data), 0);
        rst = 1'b0;

        load(4, 3, 2, 1, 4);
        go(1'b0);
        load(1, 2, 3, 4, 4);
        go(1'b1);
        load(5, 5, 2, 5, 4);
        go(1'b0);
        load(7, 0, 0, 0, 1);
        go(1'b1);
        load(0, 0, 0, 0, 0);
        go(1'b0);

        clr();
        for (int a = 0; a < 4; a++) wr(a + 8);
        @(negedge clk);
        chk("full_after_4", int'(bus.full), 1);
        wr(3);
        @(negedge clk);
        chk("count_after_5", int'(bus.count), 4);
        stim_addr = 2'd3;
        #1;
        chk("fifth_dropped", int'(bus.rd_data), 11);
        go(1'b1);

        load(4, 3, 2, 1, 4);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        stim_addr = 2'd0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_count", int'(bus.count), 0);
        chk("abort_rd_data", int'(bus.rd_data), 0);
        rst = 1'b0;
        mcnt = 0;
        repeat (10) @(negedge clk);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) != 0) clr();
            n = $urandom_range(0, 5);
            for (int a = 0; a < n; a++) wr($urandom_range(0, 15));
            go(1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
